load_store_aligner: RTL and testbench

Sequential load/store unit placed between the core's memory stage and the data-memory bus. It accepts one load or store request per handshake, generates aligned bus beats with byte enables and lane-shifted write data, and returns sign- or zero-extended load data. Misaligned accesses that straddle a bus word are split into two aligned beats and merged internally. It replaces the purely combinational store-lane/byte-enable decode with a handshaked, width-parametrised unit.

---
 rtl/holy_core_pkg.sv | 56 +++++
 rtl/load_data_extender.sv | 32 +++
 rtl/load_store_aligner.sv | 244 ++++++++++++++++++++++++
 tb/tb_load_store_aligner.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/holy_core_pkg.sv
// Shared load/store definitions: funct3 access-type codes, the LSU state
// encoding and a decoder from funct3 to access size and signedness.
package holy_core_pkg;

  localparam logic [2:0] F3_BYTE   = 3'b000;
  localparam logic [2:0] F3_HALF   = 3'b001;
  localparam logic [2:0] F3_WORD   = 3'b010;
  localparam logic [2:0] F3_DWORD  = 3'b011;
  localparam logic [2:0] F3_BYTE_U = 3'b100;
  localparam logic [2:0] F3_HALF_U = 3'b101;
  localparam logic [2:0] F3_WORD_U = 3'b110;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } lsu_state_t;

  // size_log2: 0=byte, 1=half, 2=word, 3=doubleword
  typedef struct packed {
    logic       legal;
    logic [1:0] size_log2;
    logic       is_signed;
  } f3_info_t;

  // Doubleword and word-unsigned only exist on a 64-bit datapath.
  function automatic f3_info_t decode_f3(input logic [2:0] f3, input logic xlen64);
    f3_info_t info;
    info.legal     = 1'b1;
    info.size_log2 = 2'd0;
    info.is_signed = 1'b1;
    case (f3)
      F3_BYTE:   info.size_log2 = 2'd0;
      F3_HALF:   info.size_log2 = 2'd1;
      F3_WORD:   info.size_log2 = 2'd2;
      F3_DWORD: begin
        info.size_log2 = 2'd3;
        info.legal     = xlen64;
      end
      F3_BYTE_U: info.is_signed = 1'b0;
      F3_HALF_U: begin
        info.size_log2 = 2'd1;
        info.is_signed = 1'b0;
      end
      F3_WORD_U: begin
        info.size_log2 = 2'd2;
        info.is_signed = 1'b0;
        info.legal     = xlen64;
      end
      default:   info.legal = 1'b0;
    endcase
    return info;
  endfunction

endpackage

// File: rtl/load_data_extender.sv
// Combinational load-result extender: keeps the low 'size' bytes of the
// already lane-shifted raw data and fills the rest with the sign bit of the
// access (signed loads) or zeros (unsigned loads).
module load_data_extender #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] raw,
  input  logic [1:0]      size_log2,
  input  logic            is_signed,
  output logic [XLEN-1:0] data
);

  localparam int NB = XLEN / 8;

  logic [3:0] size_b;
  logic       sign;

  // Pick the access MSB, then rebuild the result byte by byte.
  always_comb begin
    size_b = 4'd1 << size_log2;
    sign   = 1'b0;
    for (int i = 0; i < NB; i++) begin
      if (4'(i + 1) == size_b) sign = raw[8*i+7];
    end
    sign = sign & is_signed;
    data = '0;
    for (int i = 0; i < NB; i++) begin
      data[8*i +: 8] = (4'(i) < size_b) ? raw[8*i +: 8] : {8{sign}};
    end
  end

endmodule

// File: rtl/load_store_aligner.sv
// Handshaked load/store aligner between the memory stage and the data bus.
// Turns one request into one or two aligned bus beats with byte enables and
// lane-shifted write data, and returns extended load data.
// Build option MISALIGNED_SPLIT_EN: when defined, accesses straddling a bus
// word are split into two beats and merged; when undefined, any misaligned
// access is answered with rsp_err and no bus traffic.
//
// Handshakes: a request is taken when req_valid && req_ready (ready only in
// IDLE); a bus beat is taken when mem_valid && mem_ready, with all mem_*
// outputs held while waiting; read data is taken on mem_rvalid in WAIT only;
// rsp_valid is a single-cycle pulse the consumer cannot stall.
module load_store_aligner
  import holy_core_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [2:0]          req_f3,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [XLEN-1:0]     req_wdata,
  output logic                rsp_valid,
  output logic [XLEN-1:0]     rsp_rdata,
  output logic                rsp_err,
  output logic                mem_valid,
  input  logic                mem_ready,
  output logic                mem_write,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [XLEN/8-1:0]   mem_be,
  output logic [XLEN-1:0]     mem_wdata,
  input  logic                mem_rvalid,
  input  logic [XLEN-1:0]     mem_rdata
);

  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);
`ifdef MISALIGNED_SPLIT_EN
  localparam int LANES = 2 * NB;
`else
  localparam int LANES = NB;
`endif
  localparam int WW = 8 * LANES;

  lsu_state_t        state_q, state_d;
  logic              accept;
  logic              beat_done;
  f3_info_t          info_in;
  logic              bad_in;

  logic [ADDR_W-1:0] addr_q;
  logic [XLEN-1:0]   wdata_q;
  logic              write_q;
  logic [1:0]        size_q;
  logic              signed_q;
  logic              err_q;
  logic [XLEN-1:0]   slot0_q;

  logic [OFFW-1:0]   off;
  logic [3:0]        size_b;
  logic [LANES-1:0]  smask;
  logic [LANES-1:0]  be_all;
  logic [XLEN-1:0]   wdata_m;
  logic [WW-1:0]     wdata_all;
  logic [ADDR_W-1:0] base;
  logic [XLEN-1:0]   raw;
  logic [XLEN-1:0]   ext_data;

`ifdef MISALIGNED_SPLIT_EN
  logic              beat_q, beat_d;
  logic              split;
  logic [XLEN-1:0]   slot1_q;
  logic [2*XLEN-1:0] rd_all;
`endif

  assign accept = req_valid & req_ready;

  // Classify the incoming request; only consulted in the accept cycle.
  always_comb begin
    info_in = decode_f3(req_f3, XLEN == 64);
    bad_in  = ~info_in.legal;
`ifndef MISALIGNED_SPLIT_EN
    if ((5'(req_addr[OFFW-1:0]) + (5'd1 << info_in.size_log2)) > 5'(NB)) bad_in = 1'b1;
    if ((4'(req_addr[OFFW-1:0]) & ((4'd1 << info_in.size_log2) - 4'd1)) != 4'd0) bad_in = 1'b1;
`endif
  end

  // State register; reset abandons any access in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
`ifdef MISALIGNED_SPLIT_EN
      beat_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
`ifdef MISALIGNED_SPLIT_EN
      beat_q  <= beat_d;
`endif
    end
  end

  // Next-state logic: a finished beat either starts beat 1 or responds.
  always_comb begin
    state_d   = state_q;
    beat_done = 1'b0;
`ifdef MISALIGNED_SPLIT_EN
    beat_d    = beat_q;
`endif
    case (state_q)
      S_IDLE: begin
`ifdef MISALIGNED_SPLIT_EN
        beat_d = 1'b0;
`endif
        if (accept) state_d = bad_in ? S_RESP : S_ISSUE;
      end
      S_ISSUE: begin
        if (mem_ready) begin
          if (write_q) beat_done = 1'b1;
          else         state_d   = S_WAIT;
        end
      end
      S_WAIT:  if (mem_rvalid) beat_done = 1'b1;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (beat_done) begin
`ifdef MISALIGNED_SPLIT_EN
      if (split && !beat_q) begin
        beat_d  = 1'b1;
        state_d = S_ISSUE;
      end else begin
        state_d = S_RESP;
      end
`else
      state_d = S_RESP;
`endif
    end
  end

  // Capture the request so nothing downstream depends on req_* afterwards.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q   <= '0;
      wdata_q  <= '0;
      write_q  <= 1'b0;
      size_q   <= 2'd0;
      signed_q <= 1'b0;
      err_q    <= 1'b0;
    end else if (accept) begin
      addr_q   <= req_addr;
      wdata_q  <= req_wdata;
      write_q  <= req_write;
      size_q   <= info_in.size_log2;
      signed_q <= info_in.is_signed;
      err_q    <= bad_in;
    end
  end

  // Collect returned read beats into their slots.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot0_q <= '0;
`ifdef MISALIGNED_SPLIT_EN
      slot1_q <= '0;
`endif
    end else if (state_q == S_WAIT && mem_rvalid) begin
`ifdef MISALIGNED_SPLIT_EN
      if (beat_q) slot1_q <= mem_rdata;
      else        slot0_q <= mem_rdata;
`else
      slot0_q <= mem_rdata;
`endif
    end
  end

  // Lane placement of enables and write data across one or two bus words.
  always_comb begin
    off    = addr_q[OFFW-1:0];
    size_b = 4'd1 << size_q;
    base   = {addr_q[ADDR_W-1:OFFW], {OFFW{1'b0}}};
    smask  = '0;
    for (int i = 0; i < LANES; i++) begin
      if (5'(i) < 5'(size_b)) smask[i] = 1'b1;
    end
    wdata_m = '0;
    for (int i = 0; i < NB; i++) begin
      if (4'(i) < size_b) wdata_m[8*i +: 8] = wdata_q[8*i +: 8];
    end
    be_all    = smask << off;
    wdata_all = WW'(wdata_m) << {off, 3'b000};
  end

`ifdef MISALIGNED_SPLIT_EN
  assign split = (5'(off) + 5'(size_b)) > 5'(NB);

  // Bring the addressed bytes of the two-word window down to lane 0.
  always_comb begin
    rd_all = {slot1_q, slot0_q};
    raw    = '0;
    for (int i = 0; i < NB; i++) begin
      raw[8*i +: 8] = rd_all[8*(i + int'(off)) +: 8];
    end
  end
`else
  assign raw = slot0_q >> {off, 3'b000};
`endif

  load_data_extender #(.XLEN(XLEN)) u_ext (
    .raw       (raw),
    .size_log2 (size_q),
    .is_signed (signed_q),
    .data      (ext_data)
  );

  // Output decode; bus and response fields read zero when not qualified.
  always_comb begin
    req_ready = (state_q == S_IDLE) & rst_n;
    mem_valid = (state_q == S_ISSUE);
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_be    = '0;
    mem_wdata = '0;
    if (mem_valid) begin
      mem_write = write_q;
`ifdef MISALIGNED_SPLIT_EN
      mem_addr  = beat_q ? base + ADDR_W'(NB) : base;
      mem_be    = beat_q ? be_all[2*NB-1:NB] : be_all[NB-1:0];
      mem_wdata = beat_q ? wdata_all[2*XLEN-1:XLEN] : wdata_all[XLEN-1:0];
`else
      mem_addr  = base;
      mem_be    = be_all;
      mem_wdata = wdata_all;
`endif
    end
    rsp_valid = (state_q == S_RESP);
    rsp_err   = rsp_valid & err_q;
    rsp_rdata = (rsp_valid && !err_q && !write_q) ? ext_data : '0;
  end

endmodule

// File: tb/tb_load_store_aligner.sv
// Bench for load_store_aligner at XLEN=32: a table of directed requests with
// hand-computed beats and responses, plus sequences for reset, bus stalls,
// stray read-valid and reset during a pending read.
module tb_load_store_aligner;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_f3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_valid;
  logic        mem_ready;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  localparam int W = 69;  // {write, addr[31:0], be[3:0], wdata[31:0]}
  logic [W-1:0] exp_q[$];

  typedef struct {
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rd0;
    logic [31:0] rd1;
    int          nbeats;
    logic [31:0] a0;
    logic [3:0]  be0;
    logic [31:0] w0;
    logic [31:0] a1;
    logic [3:0]  be1;
    logic [31:0] w1;
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } vec_t;

  vec_t vecs[16];
  int   n_vecs = 0;

  load_store_aligner #(.XLEN(32), .ADDR_W(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_f3     (req_f3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] rd0, input logic [31:0] rd1,
                              input int nbeats, input logic [31:0] a0, input logic [3:0] be0,
                              input logic [31:0] w0, input logic [31:0] a1, input logic [3:0] be1,
                              input logic [31:0] w1, input logic [31:0] rdata, input logic err,
                              input int cyc);
    vec_t v;
    v.wr = wr; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rd0 = rd0; v.rd1 = rd1;
    v.nbeats = nbeats; v.a0 = a0; v.be0 = be0; v.w0 = w0; v.a1 = a1; v.be1 = be1; v.w1 = w1;
    v.rdata = rdata; v.err = err; v.cyc = cyc;
    return v;
  endfunction

  function automatic vec_t mk_err(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                                  input logic [31:0] wdata);
    return mk(wr, f3, addr, wdata, 32'h0, 32'h0, 0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0,
              32'h0, 1'b1, 1);
  endfunction

  task automatic add(input vec_t v);
    vecs[n_vecs] = v;
    n_vecs++;
  endtask

  task automatic idle_inputs();
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_f3     = 3'b000;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    mem_ready  = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
  endtask

  // Driver: present one request for a single cycle (caller is at a negedge).
  task automatic send_req(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata);
    req_valid = 1'b1;
    req_write = wr;
    req_f3    = f3;
    req_addr  = addr;
    req_wdata = wdata;
    @(negedge clk);
    req_valid = 1'b0;
    req_write = 1'b0;
    req_f3    = 3'b000;
    req_addr  = 32'h0;
    req_wdata = 32'h0;
  endtask

  // Run one table entry with an always-ready bus and read data one cycle
  // after each read beat; beats are scored against exp_q.
  task automatic run_vec(input vec_t v, input string tag);
    int cyc;
    int beats;
    bit got;
    bit pend;
    logic [W-1:0] e;
    exp_q.delete();
    if (v.nbeats > 0) exp_q.push_back({v.wr, v.a0, v.be0, v.w0});
    if (v.nbeats > 1) exp_q.push_back({v.wr, v.a1, v.be1, v.w1});
    @(negedge clk);
    check({tag, " req_ready"}, 32'(req_ready), 32'h1);
    send_req(v.wr, v.f3, v.addr, v.wdata);
    cyc = 1; beats = 0; got = 1'b0; pend = 1'b0;
    while (!got && cyc < 40) begin
      mem_ready  = 1'b0;
      mem_rvalid = 1'b0;
      mem_rdata  = 32'h0;
      if (rsp_valid) begin
        got = 1'b1;
        check({tag, " rsp_cycle"}, 32'(cyc), 32'(v.cyc));
        check({tag, " rsp_err"}, 32'(rsp_err), 32'(v.err));
        check({tag, " rsp_rdata"}, rsp_rdata, v.rdata);
      end else if (pend) begin
        mem_rvalid = 1'b1;
        mem_rdata  = (beats == 1) ? v.rd0 : v.rd1;
        pend = 1'b0;
      end else if (mem_valid) begin
        if (exp_q.size() == 0) begin
          check({tag, " extra_beat"}, 32'(beats + 1), 32'(v.nbeats));
        end else begin
          e = exp_q.pop_front();
          check({tag, " mem_write"}, 32'(mem_write), 32'(e[68]));
          check({tag, " mem_addr"}, mem_addr, e[67:36]);
          check({tag, " mem_be"}, 32'(mem_be), 32'(e[35:32]));
          check({tag, " mem_wdata"}, mem_wdata, e[31:0]);
        end
        mem_ready = 1'b1;
        if (!mem_write) pend = 1'b1;
        beats++;
      end
      if (!got) begin
        @(negedge clk);
        cyc++;
      end
    end
    check({tag, " rsp_seen"}, 32'(got), 32'h1);
    check({tag, " beat_count"}, 32'(beats), 32'(v.nbeats));
    @(negedge clk);
    check({tag, " rsp_single_pulse"}, 32'(rsp_valid), 32'h0);
    check({tag, " ready_after_rsp"}, 32'(req_ready), 32'h1);
  endtask

  initial begin
    // clock / reset block
    rst_n = 1'b0;
    idle_inputs();

    // ---- stimulus table (XLEN=32) ----
    add(mk(1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 0, 1, 32'h100, 4'hF, 32'hDEADBEEF, 0, 0, 0, 0, 0, 2));
    add(mk(0, 3'b000, 32'h103, 0, 32'h80123456, 0, 1, 32'h100, 4'h8, 0, 0, 0, 0, 32'hFFFFFF80, 0, 3));
    add(mk(0, 3'b100, 32'h103, 0, 32'h80123456, 0, 1, 32'h100, 4'h8, 0, 0, 0, 0, 32'h00000080, 0, 3));
`ifdef MISALIGNED_SPLIT_EN
    add(mk(1, 3'b010, 32'h102, 32'h11223344, 0, 0, 2, 32'h100, 4'hC, 32'h33440000,
           32'h104, 4'h3, 32'h00001122, 0, 0, 3));
    add(mk(0, 3'b001, 32'h0FF, 0, 32'hAB000000, 32'h000000CD, 2, 32'h0FC, 4'h8, 0,
           32'h100, 4'h1, 0, 32'hFFFFCDAB, 0, 5));
`else
    add(mk_err(1, 3'b010, 32'h102, 32'h11223344));
    add(mk_err(0, 3'b001, 32'h0FF, 32'h0));
`endif
    add(mk_err(0, 3'b011, 32'h100, 32'h0));
    add(mk(0, 3'b101, 32'h102, 0, 32'h87651234, 0, 1, 32'h100, 4'hC, 0, 0, 0, 0, 32'h00008765, 0, 3));
    add(mk(1, 3'b000, 32'h101, 32'hFFFFFFA5, 0, 0, 1, 32'h100, 4'h2, 32'h0000A500, 0, 0, 0, 0, 0, 2));
    add(mk(1, 3'b001, 32'h102, 32'h1234BEEF, 0, 0, 1, 32'h100, 4'hC, 32'hBEEF0000, 0, 0, 0, 0, 0, 2));
    add(mk(0, 3'b010, 32'h200, 0, 32'hCAFEF00D, 0, 1, 32'h200, 4'hF, 0, 0, 0, 0, 32'hCAFEF00D, 0, 3));
    add(mk_err(1, 3'b110, 32'h100, 32'h1));
`ifdef MISALIGNED_SPLIT_EN
    add(mk(0, 3'b001, 32'h101, 0, 32'h00F1E200, 0, 1, 32'h100, 4'h6, 0, 0, 0, 0, 32'hFFFFF1E2, 0, 3));
    add(mk(1, 3'b001, 32'h103, 32'h0000CAFE, 0, 0, 2, 32'h100, 4'h8, 32'hFE000000,
           32'h104, 4'h1, 32'h000000CA, 0, 0, 3));
    add(mk(1, 3'b010, 32'hFFFFFFFE, 32'hA1B2C3D4, 0, 0, 2, 32'hFFFFFFFC, 4'hC, 32'hC3D40000,
           32'h00000000, 4'h3, 32'h0000A1B2, 0, 0, 3));
`else
    add(mk_err(0, 3'b001, 32'h101, 32'h0));
    add(mk_err(1, 3'b001, 32'h103, 32'h0000CAFE));
    add(mk_err(1, 3'b010, 32'hFFFFFFFE, 32'hA1B2C3D4));
`endif
    add(mk(0, 3'b000, 32'h0FF, 0, 32'h7F000000, 0, 1, 32'h0FC, 4'h8, 0, 0, 0, 0, 32'h0000007F, 0, 3));
    add(mk_err(0, 3'b111, 32'h100, 32'h0));

    // ---- reset state ----
    repeat (3) @(negedge clk);
    check("reset req_ready", 32'(req_ready), 32'h0);
    check("reset mem_valid", 32'(mem_valid), 32'h0);
    check("reset mem_write", 32'(mem_write), 32'h0);
    check("reset mem_addr", mem_addr, 32'h0);
    check("reset mem_be", 32'(mem_be), 32'h0);
    check("reset mem_wdata", mem_wdata, 32'h0);
    check("reset rsp_valid", 32'(rsp_valid), 32'h0);
    check("reset rsp_err", 32'(rsp_err), 32'h0);
    check("reset rsp_rdata", rsp_rdata, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset req_ready", 32'(req_ready), 32'h1);

    // ---- table-driven vectors ----
    for (int i = 0; i < n_vecs; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // ---- store held by mem_ready low for 5 cycles ----
    @(negedge clk);
    send_req(1'b1, 3'b010, 32'h104, 32'h55AA55AA);
    for (int k = 1; k <= 6; k++) begin
      check($sformatf("stall c%0d mem_valid", k), 32'(mem_valid), 32'h1);
      check($sformatf("stall c%0d mem_write", k), 32'(mem_write), 32'h1);
      check($sformatf("stall c%0d mem_addr", k), mem_addr, 32'h104);
      check($sformatf("stall c%0d mem_be", k), 32'(mem_be), 32'hF);
      check($sformatf("stall c%0d mem_wdata", k), mem_wdata, 32'h55AA55AA);
      check($sformatf("stall c%0d rsp_valid", k), 32'(rsp_valid), 32'h0);
      mem_ready = (k == 6);
      @(negedge clk);
    end
    mem_ready = 1'b0;
    check("stall rsp_valid", 32'(rsp_valid), 32'h1);
    check("stall rsp_err", 32'(rsp_err), 32'h0);
    check("stall rsp_rdata", rsp_rdata, 32'h0);
    @(negedge clk);
    check("stall rsp_single_pulse", 32'(rsp_valid), 32'h0);

    // ---- mem_rvalid while still in ISSUE is ignored ----
    send_req(1'b0, 3'b010, 32'h300, 32'h0);
    check("stray c1 mem_valid", 32'(mem_valid), 32'h1);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h12345678;
    @(negedge clk);
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
    check("stray c2 mem_valid", 32'(mem_valid), 32'h1);
    check("stray c2 rsp_valid", 32'(rsp_valid), 32'h0);
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    check("stray c3 mem_valid", 32'(mem_valid), 32'h0);
    check("stray c3 rsp_valid", 32'(rsp_valid), 32'h0);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h0BADF00D;
    @(negedge clk);
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
    check("stray c4 rsp_valid", 32'(rsp_valid), 32'h1);
    check("stray c4 rsp_rdata", rsp_rdata, 32'h0BADF00D);
    @(negedge clk);

    // ---- reset while waiting for read data ----
    send_req(1'b0, 3'b010, 32'h300, 32'h0);
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    check("rst_wait mem_valid_in_wait", 32'(mem_valid), 32'h0);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_wait mem_valid", 32'(mem_valid), 32'h0);
    check("rst_wait rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_wait req_ready", 32'(req_ready), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_wait ready_after_release", 32'(req_ready), 32'h1);
    check("rst_wait no_late_rsp", 32'(rsp_valid), 32'h0);
    run_vec(vecs[9], "post_reset_lw");

    // ---- final report ----
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
